// File: rtl/dlfloat16_pkg.sv
// Shared constants for the DLfloat16 arithmetic cluster: unit enable codes and
// exception flag layout.
package dlfloat16_pkg;

  localparam int unsigned FLAG_W = 5;

  typedef enum logic [3:0] {
    ENA_IDLE = 4'b0000,
    ENA_OP0  = 4'b0001,
    ENA_MUL  = 4'b0010,
    ENA_OP2  = 4'b0100,
    ENA_OP3  = 4'b1000
  } ena_e;

  localparam int unsigned FLG_INVALID   = 4;
  localparam int unsigned FLG_INEXACT   = 3;
  localparam int unsigned FLG_OVERFLOW  = 2;
  localparam int unsigned FLG_UNDERFLOW = 1;
  localparam int unsigned FLG_DIVZERO   = 0;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/dlfloat16_fifo.sv
// Show-ahead synchronous FIFO: head is read straight from storage, and a write
// is accepted while full provided the head is popped on the same edge.
module dlfloat16_fifo
  import dlfloat16_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dlfloat16_wb_queue.sv
// Writeback queue behind the DLfloat16 units: tracks the one-cycle unit latency,
// buffers results with credit-based issue back-pressure, keeps sticky flags.
module dlfloat16_wb_queue
  import dlfloat16_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RES_W  = 32,
  parameter int unsigned FLAG_W = dlfloat16_pkg::FLAG_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   issue_ena,
  output logic                         issue_ready,
  input  logic [RES_W-1:0]             unit_res,
  input  logic [FLAG_W-1:0]            unit_flags,
  output logic                         res_valid,
  output logic [RES_W-1:0]             res_data,
  output logic [FLAG_W-1:0]            res_flags,
  output logic [3:0]                   res_op,
  input  logic                         res_ready,
  output logic [FLAG_W-1:0]            fflags,
  input  logic                         fflags_clr,
  output logic                         err_issue,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = RES_W + FLAG_W + 4;

  logic              pend_vld;
  logic [3:0]        pend_op;
  logic              legal;
  logic              accept;
  logic              pop;
  logic              empty;
  logic [ENT_W-1:0]  head;
  logic [RES_W-1:0]  head_res;
  logic [FLAG_W-1:0] head_flags;
  logic [3:0]        head_op;

  // The in-flight op already owns a slot, so count it against the credit.
  assign issue_ready = ({1'b0, count} + (CNT_W+1)'(pend_vld)) < (CNT_W+1)'(DEPTH);
  assign legal       = is_onehot4(issue_ena);
  assign accept      = legal && issue_ready;
  assign res_valid   = !empty;
  assign pop         = res_valid && res_ready;

  dlfloat16_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pend_vld),
    .wr_data ({unit_res, unit_flags, pend_op}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty),
    .count   (count)
  );

  // Storage is not reset, so the head is masked to keep idle outputs at zero.
  assign {head_res, head_flags, head_op} = head;
  assign res_data  = res_valid ? head_res   : '0;
  assign res_flags = res_valid ? head_flags : '0;
  assign res_op    = res_valid ? head_op    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_op   <= '0;
      fflags    <= '0;
      err_issue <= 1'b0;
    end else begin
      pend_vld <= accept;
      pend_op  <= accept ? issue_ena : '0;
      fflags   <= (fflags_clr ? '0 : fflags) | (pend_vld ? unit_flags : '0);
      if ((issue_ena != '0) && !accept) err_issue <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dlfloat16_wb_queue.sv
// Randomized and directed bench for dlfloat16_wb_queue against a queue-based
// reference model of the writeback behaviour.
module tb_dlfloat16_wb_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  issue_ena;
  logic        issue_ready;
  logic [31:0] unit_res;
  logic [4:0]  unit_flags;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_flags;
  logic [3:0]  res_op;
  logic        res_ready;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        err_issue;
  logic [2:0]  count;

  dlfloat16_wb_queue #(
    .DEPTH  (DEPTH),
    .RES_W  (32),
    .FLAG_W (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_ena   (issue_ena),
    .issue_ready (issue_ready),
    .unit_res    (unit_res),
    .unit_flags  (unit_flags),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_flags   (res_flags),
    .res_op      (res_op),
    .res_ready   (res_ready),
    .fflags      (fflags),
    .fflags_clr  (fflags_clr),
    .err_issue   (err_issue),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    logic [3:0]  op;
  } ent_t;

  ent_t       q[$];
  bit         m_pend;
  logic [3:0] m_pend_op;
  logic [4:0] m_fflags;
  bit         m_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count", 64'(count), 64'(q.size()));
    chk("issue_ready", 64'(issue_ready), 64'((q.size() + int'(m_pend)) < DEPTH));
    chk("res_valid", 64'(res_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("res_data", 64'(res_data), 64'(q[0].r));
      chk("res_flags", 64'(res_flags), 64'(q[0].f));
      chk("res_op", 64'(res_op), 64'(q[0].op));
    end else begin
      chk("res_data_idle", 64'(res_data), 64'(0));
    end
    chk("fflags", 64'(fflags), 64'(m_fflags));
    chk("err_issue", 64'(err_issue), 64'(m_err));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [3:0] ena, input logic [31:0] r, input logic [4:0] f,
                      input logic rdy, input logic clr);
    ent_t e;
    bit   ready_m;
    bit   legal;
    issue_ena  = ena;
    unit_res   = r;
    unit_flags = f;
    res_ready  = rdy;
    fflags_clr = clr;
    #1;
    check_outputs();
    ready_m = (q.size() + int'(m_pend)) < DEPTH;
    legal   = ($countones(ena) == 1);
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (m_pend) begin
      e.r = r; e.f = f; e.op = m_pend_op;
      q.push_back(e);
    end
    m_fflags  = (clr ? 5'b0 : m_fflags) | (m_pend ? f : 5'b0);
    if (ena != 4'b0 && !(legal && ready_m)) m_err = 1'b1;
    m_pend    = legal && ready_m;
    m_pend_op = ena;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n      = 1'b0;
    issue_ena  = '0;
    res_ready  = 1'b0;
    fflags_clr = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_issue_ready", 64'(issue_ready), 64'(1));
    chk("rst_fflags", 64'(fflags), 64'(0));
    chk("rst_err", 64'(err_issue), 64'(0));
    q.delete();
    m_pend = 0; m_pend_op = '0; m_fflags = '0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (6) step(4'b0000, $urandom, 5'($urandom), 1'b1, 1'b0);
  endtask

  logic [3:0] ena_tab [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0001,
                               4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0110, 4'b1111};

  initial begin
    rst_n = 1'b0; issue_ena = '0; unit_res = '0; unit_flags = '0;
    res_ready = 1'b0; fflags_clr = 1'b0;
    @(negedge clk);
    do_reset();

    // single multiply: issue in N, unit output in N+1, head visible in N+2
    step(4'b0010, $urandom, 5'($urandom), 1'b0, 1'b0);
    step(4'b0000, 32'h0000_3E00, 5'b0, 1'b0, 1'b0);
    chk("mul_valid", 64'(res_valid), 64'(1));
    chk("mul_data", 64'(res_data), 64'h3E00);
    chk("mul_op", 64'(res_op), 64'(4'b0010));
    drain();

    // sticky flags, then clear with same-cycle capture
    step(4'b0000, '0, '0, 1'b1, 1'b1);
    step(4'b0001, $urandom, 5'b0, 1'b1, 1'b0);
    step(4'b0001, $urandom, 5'b00100, 1'b1, 1'b0);
    step(4'b0000, $urandom, 5'b01000, 1'b1, 1'b0);
    chk("fflags_or", 64'(fflags), 64'(5'b01100));
    step(4'b0100, $urandom, 5'b0, 1'b1, 1'b0);
    step(4'b0000, $urandom, 5'b00001, 1'b1, 1'b1);
    chk("fflags_clr", 64'(fflags), 64'(5'b00001));
    drain();

    // back-pressure: four accepted, fifth dropped
    for (int i = 0; i < 4; i++) step(4'b0010, $urandom, 5'($urandom), 1'b0, 1'b0);
    chk("bp_ready_low", 64'(issue_ready), 64'(0));
    step(4'b0010, $urandom, 5'($urandom), 1'b0, 1'b0);
    chk("bp_err", 64'(err_issue), 64'(1));
    chk("bp_count", 64'(count), 64'(4));
    drain();

    // offset pointers, then full occupancy with simultaneous capture and pop
    step(4'b1000, $urandom, 5'($urandom), 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) step(ena_tab[i], $urandom, 5'($urandom), 1'b0, 1'b0);
    chk("full_count3", 64'(count), 64'(3));
    step(4'b0000, $urandom, 5'($urandom), 1'b1, 1'b0);
    chk("full_simul_count", 64'(count), 64'(3));
    drain();

    // illegal issue
    do_reset();
    step(4'b0110, $urandom, 5'($urandom), 1'b1, 1'b0);
    step(4'b0000, $urandom, 5'($urandom), 1'b1, 1'b0);
    chk("illegal_count", 64'(count), 64'(0));
    chk("illegal_err", 64'(err_issue), 64'(1));

    // reset mid-flight with two stored and one pending
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0001, $urandom, 5'($urandom), 1'b0, 1'b0);
    chk("mid_count2", 64'(count), 64'(2));
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(ena_tab[$urandom_range(11, 0)], $urandom, 5'($urandom),
           1'($urandom_range(3, 0) != 0), 1'($urandom_range(9, 0) == 0));
      if (i == 200) do_reset();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dlfloat16_wb_queue.md
# dlfloat16_wb_queue

Writeback stage directly downstream of the DLfloat16 arithmetic units (multiplier and siblings selected by one-hot `ena`). It tracks each issued operation across the units' one-cycle registered output and captures the 32-bit result and 5-bit exception flags into a small FIFO. It presents them to the register-file writer over a valid/ready handshake and maintains a sticky accumulated exception-flag register. It also back-pressures issue so that no captured result is ever lost.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `RES_W`, default 32: result width; matches the unit `c_*` output.
- `FLAG_W`, default 5: flag width, ordered {invalid, inexact, overflow, underflow, div_zero} as bits 4..0.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `issue_ena`, in, 4: the `ena` driven to the units this cycle.
- `issue_ready`, out, 1: high when a new issue may be accepted this cycle.
- `unit_res`, in, RES_W: the selected unit's registered result.
- `unit_flags`, in, FLAG_W: the selected unit's registered exception flags.
- `res_valid`, out, 1: head entry is valid.
- `res_data`, out, RES_W: head result.
- `res_flags`, out, FLAG_W: head flags.
- `res_op`, out, 4: `ena` code that produced the head entry.
- `res_ready`, in, 1: consumer accepts the head entry.
- `fflags`, out, FLAG_W: sticky OR of the flags of all captured results.
- `fflags_clr`, in, 1: clear `fflags`.
- `err_issue`, out, 1: sticky; set on an illegal or back-pressured issue.
- `count`, out, $clog2(DEPTH+1): occupied entries.

## Operation
- **Legal issue:** `issue_ena` has exactly one bit set and `issue_ready`=1. An all-zero value is idle. Any other non-zero value is dropped, sets `err_issue`, and captures nothing.
- **Issue while `issue_ready`=0:** dropped, sets `err_issue`.
- **In-flight tracking:** a legal issue sets `pend_vld` and `pend_op <= issue_ena` for exactly one cycle.
- **Capture:** when `pend_vld`=1, the block writes {`unit_res`, `unit_flags`, `pend_op`} at the tail on that clock edge.
- **Credit rule:** `issue_ready = (count + pend_vld + 0) < DEPTH`. An accepted issue therefore always has a free slot at capture, with or without a pop.
- **Pop:** occurs when `res_valid` && `res_ready`. The FIFO is show-ahead: `res_*` reflect the head combinationally from storage; no output register.
- **Simultaneous capture and pop:** permitted at any occupancy, including full. `count` is unchanged.
- **`fflags` update:** `fflags <= (fflags_clr ? 0 : fflags) | (capture ? unit_flags : 0)`. Clear removes old bits; a same-cycle capture's flags survive.
- **`err_issue`:** cleared only by reset.
- **Pointers:** read/write pointers are log2(DEPTH) bits, wrap naturally, plus a separate occupancy counter.

## Timing
- **Reset:** all outputs are 0 except `issue_ready`=1. Pointers, `count`, `pend_vld`, `fflags` and `err_issue` are 0. Reset mid-flight discards pending and stored entries.
- **Latency:** issue in cycle N → unit output valid in N+1 → captured at the end of N+1 → `res_valid`=1 in N+2 if the FIFO was empty.
- **Throughput:** one issue per cycle sustained while `res_ready`=1.
- **`issue_ready` low:** drops in the cycle where `count + pend_vld` reaches DEPTH. It rises the cycle after a pop frees credit.
- **`fflags`:** reflects a capture in the cycle after the capture edge.

## Structure
- **Package `dlfloat16_pkg`:**
  - ena codes `ENA_OP0`=4'b0001, `ENA_MUL`=4'b0010, `ENA_OP2`=4'b0100, `ENA_OP3`=4'b1000.
  - Flag bit indices `FLG_INVALID`=4, `FLG_INEXACT`=3, `FLG_OVERFLOW`=2, `FLG_UNDERFLOW`=1, `FLG_DIVZERO`=0.
  - `FLAG_W`.
- **Sub-module `dlfloat16_fifo`:** generic show-ahead synchronous FIFO (width, depth), instantiated with width RES_W+FLAG_W+4.
- **Top level:** holds the issue check, pending register, credit logic and sticky registers.

## Test plan
- **Single mul:** `issue_ena`=0010 in N, `unit_res`=32'h0000_3E00 and `unit_flags`=0 in N+1 → `res_valid` in N+2 with `res_data`=32'h0000_3E00, `res_op`=0010.
- **Back-pressure:** `res_ready`=0, issue every cycle → four entries captured, `issue_ready` falls after the 4th accepted issue, and a 5th issue sets `err_issue`. Then `res_ready`=1 drains in order.
- **Sticky flags:** capture flags 5'b00100 then 5'b01000 → `fflags`=5'b01100. Then `fflags_clr` plus a same-cycle capture of 5'b00001 → `fflags`=5'b00001.
- **Illegal issue:** `issue_ena`=0110 → no capture, `count` stays 0, `err_issue`=1.
- **Full with simultaneous capture and pop:** at `count`=3 with `pend_vld`=1 and `res_ready`=1 → `count` stays 3 and FIFO order is preserved across pointer wrap.
- **Reset mid-flight:** `rst_n` low with 2 entries stored and one pending → `count`=0 and `res_valid`=0 immediately, `issue_ready`=1.
